// File: rtl/io_pkg.sv
// Shared definitions for IObuf clients: FSM state encoding and the
// operation code of a single byte transaction on the UART channel.
package io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } io_state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } io_op_t;

endpackage

// File: rtl/io_arbiter_if.sv
// Requester-side and IObuf-side signals of the arbiter bundled together.
// slave is the arbiter's view; master is the view of whoever drives the
// requesters and the IObuf (a testbench or the surrounding system).
interface io_arbiter_if #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) ();

   logic [NREQ-1:0]   req_rd;
   logic [NREQ-1:0]   req_wr;
   logic [8*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]   req_done;
   logic [7:0]        req_rdata;
   logic              busy;
   logic [IDW-1:0]    owner;
   logic              io_read_req;
   logic              io_write_req;
   logic [7:0]        io_din;
   logic              io_ready;
   logic              io_done;
   logic [7:0]        io_dout;

   modport slave (
      input  req_rd, req_wr, req_wdata, io_ready, io_done, io_dout,
      output req_done, req_rdata, busy, owner, io_read_req, io_write_req, io_din
   );

   modport master (
      output req_rd, req_wr, req_wdata, io_ready, io_done, io_dout,
      input  req_done, req_rdata, busy, owner, io_read_req, io_write_req, io_din
   );

endinterface

// File: rtl/io_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first pending requester
// at or after the pointer, wrapping modulo N.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  pend,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   function automatic logic [IW-1:0] slot(input logic [IW-1:0] base, input int k);
      return IW'((int'(base) + k) % N);
   endfunction

   // Scan from the farthest slot back to the pointer so the closest hit wins.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves
      // it unassigned and no latch is inferred.
      valid = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (pend[slot(ptr, k)]) begin
            valid = 1'b1;
            idx   = slot(ptr, k);
         end
      end
   end

endmodule

// File: rtl/io_arbiter.sv
// Shares one IObuf byte channel between NREQ requesters. Round-robin grant,
// one transaction outstanding; the result goes back to the owner only.
module io_arbiter
   import io_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input logic         CLK,
   input logic         RSTN,
   io_arbiter_if.slave bus
);

   io_state_t       state, state_d;
   io_op_t          op, op_d;
   logic [IDW-1:0]  rr_ptr, rr_ptr_d;
   logic [IDW-1:0]  owner_d;
   logic            busy_d;
   logic [NREQ-1:0] done_d;
   logic [7:0]      rdata_d;
   logic [7:0]      din_d;
   logic            rd_req_d;
   logic            wr_req_d;

   logic [NREQ-1:0] pend;
   logic            pick_valid;
   logic [IDW-1:0]  pick_idx;
   logic            pick_rd;
   logic [IDW-1:0]  next_ptr;

   assign pend     = bus.req_rd | bus.req_wr;
   assign pick_rd  = bus.req_rd[pick_idx];
   assign next_ptr = (bus.owner == IDW'(NREQ - 1)) ? '0 : bus.owner + IDW'(1);

   rr_pick #(
      .N  (NREQ),
      .IW (IDW)
   ) u_pick (
      .pend  (pend),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d  = state;
      op_d     = op;
      rr_ptr_d = rr_ptr;
      owner_d  = bus.owner;
      busy_d   = bus.busy;
      done_d   = '0;
      rdata_d  = bus.req_rdata;
      din_d    = bus.io_din;
      rd_req_d = 1'b0;
      wr_req_d = 1'b0;

      case (state)
         IDLE: begin
            if (bus.io_ready && pick_valid) begin
               owner_d  = pick_idx;
               op_d     = pick_rd ? OP_RD : OP_WR;
               din_d    = bus.req_wdata[{pick_idx, 3'b000} +: 8];
               busy_d   = 1'b1;
               rd_req_d = pick_rd;
               wr_req_d = !pick_rd;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.io_done) begin
               if (op == OP_RD) begin
                  rdata_d = bus.io_dout;
               end
               done_d[bus.owner] = 1'b1;
               state_d           = DONE;
            end
         end
         DONE: begin
            busy_d   = 1'b0;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; async reset returns to IDLE with pulses cleared.
   always_ff @(posedge CLK or negedge RSTN) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      if (!RSTN) begin
         state            <= IDLE;
         op               <= OP_RD;
         rr_ptr           <= '0;
         bus.owner        <= '0;
         bus.busy         <= 1'b0;
         bus.req_done     <= '0;
         bus.req_rdata    <= '0;
         bus.io_read_req  <= 1'b0;
         bus.io_write_req <= 1'b0;
         bus.io_din       <= '0;
      end else begin
         state            <= state_d;
         op               <= op_d;
         rr_ptr           <= rr_ptr_d;
         bus.owner        <= owner_d;
         bus.busy         <= busy_d;
         bus.req_done     <= done_d;
         bus.req_rdata    <= rdata_d;
         bus.io_read_req  <= rd_req_d;
         bus.io_write_req <= wr_req_d;
         bus.io_din       <= din_d;
      end
   end

endmodule

// File: tb/tb_io_arbiter.sv
// Bench for io_arbiter: IObuf behavioural model with configurable done delay,
// a transaction-level reference monitor, directed cases and a random phase.
module tb_io_arbiter;

   localparam int NREQ = 2;
   localparam int IDW  = 1;

   logic CLK  = 1'b0;
   logic RSTN = 1'b0;

   io_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   io_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- IObuf model (acts on negedges) ----------------
   int         done_delay = 5;
   logic       stall      = 1'b0;
   logic       spurious   = 1'b0;
   logic       rand_mode  = 1'b0;
   logic [7:0] rd_byte    = 8'h00;

   initial begin : iobuf_model
      int   cnt;
      logic active;
      logic cur_rd;
      cnt          = 0;
      active       = 1'b0;
      cur_rd       = 1'b0;
      bus.io_ready = 1'b1;
      bus.io_done  = 1'b0;
      bus.io_dout  = 8'h00;
      forever begin
         @(negedge CLK);
         if (!RSTN) begin
            active       = 1'b0;
            cnt          = 0;
            bus.io_ready = 1'b1;
            bus.io_done  = 1'b0;
         end else begin
            bus.io_done = 1'b0;
            if (bus.io_read_req || bus.io_write_req) begin
               active       = 1'b1;
               cur_rd       = bus.io_read_req;
               cnt          = done_delay;
               bus.io_ready = 1'b0;
               if (rand_mode) rd_byte = 8'($urandom);
            end else if (active) begin
               cnt--;
               if (cnt <= 0) begin
                  active      = 1'b0;
                  bus.io_done = 1'b1;
                  bus.io_dout = cur_rd ? rd_byte : 8'($urandom);
               end
            end else if (spurious) begin
               spurious    = 1'b0;
               bus.io_done = 1'b1;
               bus.io_dout = 8'hEE;
            end else begin
               bus.io_ready = !stall;
            end
         end
      end
   end

   // ---------------- Reference monitor (samples #1 after posedge) ----------------
   typedef enum {M_FREE, M_ACTIVE, M_AFTER} mphase_t;

   mphase_t        m_phase = M_FREE;
   logic [IDW-1:0] m_rr    = '0;
   logic [IDW-1:0] m_owner = '0;
   logic           m_rd    = 1'b0;
   logic [7:0]     m_rdata = 8'h00;
   int             m_age   = 0;
   int             done_order[$];

   function automatic logic [IDW-1:0] pick(input logic [NREQ-1:0] p, input logic [IDW-1:0] rr);
      for (int k = 0; k < NREQ; k++) begin
         if (p[IDW'((int'(rr) + k) % NREQ)]) return IDW'((int'(rr) + k) % NREQ);
      end
      return '0;
   endfunction

   initial begin : monitor
      logic [NREQ-1:0] pend;
      logic [NREQ-1:0] e_done;
      logic            e_rd;
      logic            e_wr;
      forever begin
         @(posedge CLK);
         #1;
         if (!RSTN) begin
            m_phase = M_FREE;
            m_rr    = '0;
            m_owner = '0;
            m_rdata = 8'h00;
         end else begin
            pend   = bus.req_rd | bus.req_wr;
            e_rd   = 1'b0;
            e_wr   = 1'b0;
            e_done = '0;
            case (m_phase)
               M_FREE: begin
                  if (bus.io_ready && pend != '0) begin
                     m_owner = pick(pend, m_rr);
                     m_rd    = bus.req_rd[m_owner];
                     e_rd    = m_rd;
                     e_wr    = !m_rd;
                     m_age   = 0;
                     m_phase = M_ACTIVE;
                     if (!m_rd)
                        check("grant_io_din", 32'(bus.io_din), 32'(bus.req_wdata[{m_owner, 3'b000} +: 8]));
                  end
               end
               M_ACTIVE: begin
                  m_age++;
                  if (m_age >= 2 && bus.io_done) begin
                     e_done[m_owner] = 1'b1;
                     if (m_rd) m_rdata = bus.io_dout;
                     m_rr    = IDW'((int'(m_owner) + 1) % NREQ);
                     done_order.push_back(int'(m_owner));
                     m_phase = M_AFTER;
                  end
               end
               default: m_phase = M_FREE;
            endcase
            check("io_read_req", 32'(bus.io_read_req), 32'(e_rd));
            check("io_write_req", 32'(bus.io_write_req), 32'(e_wr));
            check("req_done", 32'(bus.req_done), 32'(e_done));
            check("busy", 32'(bus.busy), 32'(m_phase != M_FREE));
            check("owner", 32'(bus.owner), 32'(m_owner));
            check("req_rdata", 32'(bus.req_rdata), 32'(m_rdata));
         end
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_owner"}, 32'(bus.owner), 32'd0);
      check({tag, "_req_done"}, 32'(bus.req_done), 32'd0);
      check({tag, "_req_rdata"}, 32'(bus.req_rdata), 32'd0);
      check({tag, "_io_read_req"}, 32'(bus.io_read_req), 32'd0);
      check({tag, "_io_write_req"}, 32'(bus.io_write_req), 32'd0);
      check({tag, "_io_din"}, 32'(bus.io_din), 32'd0);
   endtask

   // Waits (bounded) for a completion, expects it on requester i, optionally drops i.
   task automatic wait_done(input int i, input bit drop, input string tag);
      logic [NREQ-1:0] exp_vec;
      int n;
      exp_vec = '0;
      exp_vec[IDW'(i)] = 1'b1;
      n = 0;
      forever begin
         @(negedge CLK);
         if (bus.req_done != '0) break;
         n++;
         if (n > 200) break;
      end
      check({tag, "_done_vec"}, 32'(bus.req_done), 32'(exp_vec));
      if (drop) begin
         bus.req_rd[IDW'(i)] = 1'b0;
         bus.req_wr[IDW'(i)] = 1'b0;
      end
   endtask

   task automatic new_req(input int i);
      int kind;
      kind = $urandom_range(0, 2);
      bus.req_wdata[8*i +: 8] = 8'($urandom);
      bus.req_rd[IDW'(i)]     = (kind != 1);
      bus.req_wr[IDW'(i)]     = (kind != 0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // ---------------- Main sequence ----------------
   initial begin : main
      int completions;
      bus.req_rd    = '0;
      bus.req_wr    = '0;
      bus.req_wdata = '0;

      // Reset state
      RSTN = 1'b0;
      repeat (2) @(negedge CLK);
      check_zero_outputs("reset");
      RSTN = 1'b1;

      // 1: async reset in the middle of WAIT, then quiet channel
      done_delay = 20;
      @(negedge CLK);
      bus.req_rd[0] = 1'b1;
      repeat (6) @(negedge CLK);
      check("t1_busy_in_wait", 32'(bus.busy), 32'd1);
      @(posedge CLK);
      #3;
      RSTN = 1'b0;
      #1;
      check_zero_outputs("t1_async_reset");
      bus.req_rd = '0;
      repeat (2) @(negedge CLK);
      RSTN = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         check("t1_quiet_rd", 32'(bus.io_read_req), 32'd0);
         check("t1_quiet_wr", 32'(bus.io_write_req), 32'd0);
      end

      // 2: single read on requester 0
      done_delay = 5;
      rd_byte    = 8'h5A;
      bus.req_rd[0] = 1'b1;
      wait_done(0, 1'b1, "t2");
      check("t2_rdata", 32'(bus.req_rdata), 32'h5A);

      // 3: single write on requester 1; read data must stay
      @(negedge CLK);
      bus.req_wdata[15:8] = 8'hC3;
      bus.req_wr[1]       = 1'b1;
      wait_done(1, 1'b1, "t3");
      check("t3_rdata_kept", 32'(bus.req_rdata), 32'h5A);
      check("t3_io_din", 32'(bus.io_din), 32'hC3);

      // 4: contention from reset, four grants alternate 0,1,0,1
      @(negedge CLK);
      RSTN = 1'b0;
      done_delay          = 3;
      bus.req_rd[0]       = 1'b1;
      bus.req_wr[1]       = 1'b1;
      bus.req_wdata[15:8] = 8'h3C;
      repeat (2) @(negedge CLK);
      done_order.delete();
      RSTN = 1'b1;
      wait_done(0, 1'b0, "t4_g0");
      wait_done(1, 1'b0, "t4_g1");
      wait_done(0, 1'b0, "t4_g2");
      wait_done(1, 1'b0, "t4_g3");
      bus.req_rd = '0;
      bus.req_wr = '0;
      check("t4_count", 32'(done_order.size()), 32'd4);
      for (int k = 0; k < 4 && k < done_order.size(); k++)
         check($sformatf("t4_order%0d", k), 32'(done_order[k]), 32'(k % 2));

      // 5: rd+wr on requester 0 with the channel not ready for 10 cycles
      repeat (2) @(negedge CLK);
      stall = 1'b1;
      repeat (2) @(negedge CLK);
      rd_byte       = 8'h77;
      bus.req_rd[0] = 1'b1;
      bus.req_wr[0] = 1'b1;
      bus.req_wdata[7:0] = 8'h99;
      repeat (10) begin
         @(negedge CLK);
         check("t5_no_rd_req", 32'(bus.io_read_req), 32'd0);
         check("t5_no_wr_req", 32'(bus.io_write_req), 32'd0);
         check("t5_not_busy", 32'(bus.busy), 32'd0);
      end
      stall = 1'b0;
      wait_done(0, 1'b1, "t5");
      check("t5_read_done", 32'(bus.req_rdata), 32'h77);

      // 6: spurious io_done while idle; pointer (now 1) and rdata unchanged
      repeat (3) @(negedge CLK);
      spurious = 1'b1;
      repeat (4) @(negedge CLK);
      check("t6_no_done", 32'(bus.req_done), 32'd0);
      check("t6_rdata_kept", 32'(bus.req_rdata), 32'h77);
      rd_byte    = 8'h11;
      bus.req_rd = 2'b11;
      wait_done(1, 1'b1, "t6_first");
      wait_done(0, 1'b1, "t6_second");
      check("t6_rdata_new", 32'(bus.req_rdata), 32'h11);

      // 7: random traffic against the reference monitor
      rand_mode   = 1'b1;
      completions = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge CLK);
         stall      = ($urandom_range(0, 7) == 0);
         done_delay = $urandom_range(1, 6);
         if (bus.req_done != '0) completions++;
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_done[IDW'(i)]) begin
               bus.req_rd[IDW'(i)] = 1'b0;
               bus.req_wr[IDW'(i)] = 1'b0;
               if ($urandom_range(0, 1) == 1) new_req(i);
            end else if (bus.req_rd[IDW'(i)] || bus.req_wr[IDW'(i)]) begin
               if (!(m_phase != M_FREE && m_owner == IDW'(i)) && $urandom_range(0, 15) == 0) begin
                  bus.req_rd[IDW'(i)] = 1'b0;
                  bus.req_wr[IDW'(i)] = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               new_req(i);
            end
         end
      end
      @(negedge CLK);
      if (bus.req_done != '0) completions++;
      bus.req_rd = '0;
      bus.req_wr = '0;
      stall      = 1'b0;
      for (int n = 0; n < 100 && bus.busy; n++) @(negedge CLK);
      repeat (3) @(negedge CLK);
      check("rand_drained", 32'(bus.busy), 32'd0);
      check("rand_enough_traffic", 32'(completions > 100), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
